// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state type and round-robin helper
// for the axis_compare_arbiter slice.
package axis_arb_pkg;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_t;

   localparam int MAX_IN = 16;

   // First set bit of valid_vec scanning upward from
   // (last+1) mod n with wrap. Returns last if none set.
   function automatic logic [3:0] next_rr(
      input logic [MAX_IN-1:0] valid_vec,
      input logic [3:0]        last,
      input logic [4:0]        n
   );
      logic [3:0] win;
      logic       found;
      int         idx;
      win   = last;
      found = 1'b0;
      for (int k = 1; k <= MAX_IN; k++) begin
         idx = (int'(last) + k) % int'(n);
         if (!found && k <= int'(n) &&
             valid_vec[4'(idx)]) begin
            win   = 4'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/axis_compare_arbiter_skid.sv
// axis_skid_buffer: 2-entry AXI-Stream register slice.
// Ports: clk, reset (async, high), in_* slave, out_* master.
module axis_skid_buffer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_tdata,
   input  logic                  in_tvalid,
   input  logic                  in_tlast,
   output logic                  in_tready,
   output logic [DATA_WIDTH-1:0] out_tdata,
   output logic                  out_tvalid,
   output logic                  out_tlast,
   input  logic                  out_tready
);

   logic [DATA_WIDTH-1:0] skid_tdata;
   logic                  skid_tlast;
   logic                  skid_valid;

   // Ready is a register, so no path from out_tready.
   assign in_tready = ~skid_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_tvalid <= 1'b0;
         out_tdata  <= '0;
         out_tlast  <= 1'b0;
         skid_valid <= 1'b0;
         skid_tdata <= '0;
         skid_tlast <= 1'b0;
      end else if (out_tready || !out_tvalid) begin
         if (skid_valid) begin
            out_tvalid <= 1'b1;
            out_tdata  <= skid_tdata;
            out_tlast  <= skid_tlast;
            skid_valid <= 1'b0;
         end else begin
            out_tvalid <= in_tvalid;
            out_tdata  <= in_tdata;
            out_tlast  <= in_tlast;
         end
      end else if (in_tvalid && !skid_valid) begin
         // Output stalled: park the beat accepted this cycle.
         skid_valid <= 1'b1;
         skid_tdata <= in_tdata;
         skid_tlast <= in_tlast;
      end
   end

endmodule

// File: rtl/axis_compare_arbiter.sv
// axis_compare_arbiter: packet-locked round-robin arbiter
// sharing one AXI-Stream consumer among NUM_IN streams.
// Ports: clk, reset (async, high); in_* NUM_IN slave
// streams; out_* master stream; grant_idx, busy status.
// Macro AXIS_ARB_REG_OUT_EN: register output via skid buffer.
module axis_compare_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_IN      = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int PACKET_MODE = 1,
   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]  in_tdata,
   input  logic [NUM_IN-1:0]                  in_tvalid,
   input  logic [NUM_IN-1:0]                  in_tlast,
   output logic [NUM_IN-1:0]                  in_tready,
   output logic [DATA_WIDTH-1:0]              out_tdata,
   output logic                               out_tvalid,
   output logic                               out_tlast,
   input  logic                               out_tready,
   output logic [IDX_W-1:0]                   grant_idx,
   output logic                               busy
);

   arb_state_t            state_q, state_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic [DATA_WIDTH-1:0] arb_tdata;
   logic                  arb_tvalid;
   logic                  arb_tlast;
   logic                  arb_tready;
   logic                  arb_fire;

   assign busy       = (state_q == LOCKED);
   assign grant_idx  = grant_q;
   assign arb_tdata  = in_tdata[grant_q];
   assign arb_tvalid = busy & in_tvalid[grant_q];
   assign arb_tlast  = in_tlast[grant_q];
   assign arb_fire   = arb_tvalid & arb_tready;

   always_comb begin
      in_tready = '0;
      if (busy)
         in_tready[grant_q] = arb_tready;
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (|in_tvalid) begin
               grant_d = IDX_W'(next_rr(16'(in_tvalid),
                                        4'(last_q),
                                        5'(NUM_IN)));
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            // Beat mode releases the grant after every beat.
            if (arb_fire &&
                (arb_tlast || PACKET_MODE == 0)) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_IN - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef AXIS_ARB_REG_OUT_EN
   // Packet end is seen at the skid input, not at out.
   axis_skid_buffer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_tdata  (arb_tdata),
      .in_tvalid (arb_tvalid),
      .in_tlast  (arb_tlast),
      .in_tready (arb_tready),
      .out_tdata (out_tdata),
      .out_tvalid(out_tvalid),
      .out_tlast (out_tlast),
      .out_tready(out_tready)
   );
`else
   assign out_tdata  = arb_tdata;
   assign out_tvalid = arb_tvalid;
   assign out_tlast  = arb_tlast;
   assign arb_tready = out_tready;
`endif

endmodule

// File: tb/tb_axis_compare_arbiter.sv
// tb_axis_compare_arbiter: randomized scoreboard bench for
// axis_compare_arbiter, packet mode and beat mode instances.
module tb_axis_compare_arbiter;

   localparam int N = 4;
   localparam int W = 32;
`ifdef AXIS_ARB_REG_OUT_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic [N-1:0][W-1:0] in_tdata;
   logic [N-1:0]        in_tvalid;
   logic [N-1:0]        in_tlast;
   logic                out_tready;

   logic [N-1:0] rdy1, rdy0;
   logic [W-1:0] od1, od0;
   logic         ov1, ov0, ol1, ol0, b1, b0;
   logic [1:0]   g1, g0;

   bit           pm;
   logic [N-1:0] in_tready;
   logic [W-1:0] out_tdata;
   logic         out_tvalid, out_tlast, busy;
   logic [1:0]   grant_idx;

   assign in_tready  = pm ? rdy1 : rdy0;
   assign out_tdata  = pm ? od1 : od0;
   assign out_tvalid = pm ? ov1 : ov0;
   assign out_tlast  = pm ? ol1 : ol0;
   assign busy       = pm ? b1 : b0;
   assign grant_idx  = pm ? g1 : g0;

   axis_compare_arbiter #(
      .NUM_IN(N), .DATA_WIDTH(W), .PACKET_MODE(1)
   ) dut (
      .clk(clk), .reset(reset),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid),
      .in_tlast(in_tlast), .in_tready(rdy1),
      .out_tdata(od1), .out_tvalid(ov1),
      .out_tlast(ol1), .out_tready(out_tready),
      .grant_idx(g1), .busy(b1)
   );

   axis_compare_arbiter #(
      .NUM_IN(N), .DATA_WIDTH(W), .PACKET_MODE(0)
   ) dut_beat (
      .clk(clk), .reset(reset),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid),
      .in_tlast(in_tlast), .in_tready(rdy0),
      .out_tdata(od0), .out_tvalid(ov0),
      .out_tlast(ol0), .out_tready(out_tready),
      .grant_idx(g0), .busy(b0)
   );

   int n_pass = 0;
   int n_chk  = 0;

   // Source beats {last, data}; expected {src, last, data}.
   logic [W:0]   src_q [N][$];
   logic [W+2:0] exp_q [$];

   task automatic add_pkt(input int i, input int len);
      for (int b = 0; b < len; b++)
         src_q[i].push_back({b == len - 1, W'($urandom())});
   endtask

   // Whole-packet (or single-beat) round robin over the
   // non-empty sources, first pick after source N-1.
   task automatic build_model();
      logic [W:0] tmp [N][$];
      logic [W:0] b;
      int last;
      int pick;
      exp_q.delete();
      for (int i = 0; i < N; i++) tmp[i] = src_q[i];
      last = N - 1;
      while (1) begin
         pick = -1;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (pick < 0 && tmp[c].size() > 0) pick = c;
         end
         if (pick < 0) break;
         do begin
            b = tmp[pick].pop_front();
            exp_q.push_back({2'(pick), b});
         end while (pm && !b[W]);
         last = pick;
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      in_tvalid  = '0;
      in_tlast   = '0;
      in_tdata   = '0;
      out_tready = 1'b0;
      for (int i = 0; i < N; i++) src_q[i].delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // tr_mode: 0 ready high, 1 toggle 1010, 2 random.
   task automatic run(input int tr_mode, input bit bubbles,
                      output int last_cyc);
      bit         held [N];
      bit         mid [N];
      bit         stalled;
      bit         gap_due;
      bit         done;
      bit         bad;
      logic [W:0] prev_out;
      logic [W:0] b;
      logic [W+2:0] e;
      int         cyc;
      last_cyc = -1;
      stalled  = 0;
      gap_due  = 0;
      done     = 0;
      prev_out = '0;
      for (int i = 0; i < N; i++) begin
         held[i] = 0;
         mid[i]  = 0;
      end
      cyc = 0;
      while (cyc < 3000 && !done) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
               in_tvalid[i] = held[i] || !mid[i] ||
                              !bubbles ||
                              ($urandom_range(3) != 0);
               {in_tlast[i], in_tdata[i]} = src_q[i][0];
            end else begin
               in_tvalid[i] = 1'b0;
               in_tlast[i]  = 1'b0;
               in_tdata[i]  = '0;
            end
         end
         case (tr_mode)
            0:       out_tready = 1'b1;
            1:       out_tready = (cyc % 2 == 0);
            default: out_tready = 1'($urandom_range(1));
         endcase
         #1;
         if (stalled) begin
            n_chk++;
            if (out_tvalid !== 1'b1 ||
                {out_tlast, out_tdata} !== prev_out)
               $display("FAIL stall_hold cyc=%0d got v=%b %h exp %h",
                        cyc, out_tvalid,
                        {out_tlast, out_tdata}, prev_out);
            else n_pass++;
         end
`ifndef AXIS_ARB_REG_OUT_EN
         if (gap_due) begin
            n_chk++;
            if (out_tvalid !== 1'b0 || busy !== 1'b0)
               $display("FAIL gap cyc=%0d got v=%b busy=%b exp 0 0",
                        cyc, out_tvalid, busy);
            else n_pass++;
         end
`endif
         bad = 0;
         for (int j = 0; j < N; j++)
            if (in_tready[j] !== 1'b0 &&
                !(busy === 1'b1 && grant_idx == 2'(j)))
               bad = 1;
         n_chk++;
         if (bad)
            $display("FAIL tready_excl cyc=%0d got %b busy=%b g=%0d",
                     cyc, in_tready, busy, grant_idx);
         else n_pass++;
         gap_due = 0;
         if (out_tvalid === 1'b1 && out_tready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               $display("FAIL extra_beat cyc=%0d got %h exp none",
                        cyc, {out_tlast, out_tdata});
            end else begin
               e = exp_q.pop_front();
               if ({out_tlast, out_tdata} !== e[W:0])
                  $display("FAIL beat cyc=%0d got %h exp %h",
                           cyc, {out_tlast, out_tdata}, e[W:0]);
`ifndef AXIS_ARB_REG_OUT_EN
               else if (grant_idx !== e[W+2:W+1])
                  $display("FAIL beat_src cyc=%0d got %0d exp %0d",
                           cyc, grant_idx, e[W+2:W+1]);
`endif
               else n_pass++;
            end
            gap_due  = out_tlast || !pm;
            last_cyc = cyc;
         end
         stalled  = (out_tvalid === 1'b1) && !out_tready;
         prev_out = {out_tlast, out_tdata};
         for (int i = 0; i < N; i++) begin
            held[i] = in_tvalid[i] && !in_tready[i];
            if (in_tvalid[i] && in_tready[i]) begin
               b      = src_q[i].pop_front();
               mid[i] = !b[W];
            end
         end
         done = (exp_q.size() == 0);
         for (int i = 0; i < N; i++)
            if (src_q[i].size() != 0) done = 0;
         cyc++;
      end
      n_chk++;
      if (!done)
         $display("FAIL timeout got %0d beats left exp 0",
                  exp_q.size());
      else n_pass++;
      @(negedge clk);
      in_tvalid = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      for (int p = 0; p < 2; p++) begin
         pm = bit'(p);
         #1;
         n_chk++;
         if ({busy, grant_idx, out_tvalid, in_tready} !== 8'h00)
            $display("FAIL reset_vals pm=%0d got %h exp 00", p,
                     {busy, grant_idx, out_tvalid, in_tready});
         else n_pass++;
      end
      do_reset();
      for (int p = 0; p < 2; p++) begin
         pm = bit'(p);
         #1;
         n_chk++;
         if ({busy, grant_idx, out_tvalid, in_tready} !== 8'h00)
            $display("FAIL post_reset pm=%0d got %h exp 00", p,
                     {busy, grant_idx, out_tvalid, in_tready});
         else n_pass++;
      end
   endtask

   task automatic test_all_four();
      int lc;
      pm = 1;
      do_reset();
      for (int i = 0; i < N; i++) add_pkt(i, 4);
      build_model();
      run(0, 0, lc);
      n_chk++;
      if (lc !== 19 + LAT)
         $display("FAIL all_four_timing got %0d exp %0d",
                  lc, 19 + LAT);
      else n_pass++;
   endtask

   task automatic test_single_requester();
      int lc;
      pm = 1;
      do_reset();
      repeat (3) add_pkt(2, 2);
      build_model();
      run(0, 0, lc);
      n_chk++;
      if (lc !== 8 + LAT)
         $display("FAIL single_timing got %0d exp %0d",
                  lc, 8 + LAT);
      else n_pass++;
   endtask

   task automatic test_stall();
      int lc;
      pm = 1;
      do_reset();
      add_pkt(1, 4);
      add_pkt(3, 4);
      build_model();
      run(1, 0, lc);
   endtask

   task automatic test_beat_mode();
      int lc;
      pm = 0;
      do_reset();
      add_pkt(0, 6);
      add_pkt(1, 6);
      build_model();
      run(0, 0, lc);
      n_chk++;
      if (lc !== 23 + LAT)
         $display("FAIL beat_timing got %0d exp %0d",
                  lc, 23 + LAT);
      else n_pass++;
   endtask

   task automatic test_reset_mid_packet();
      int lc;
      pm = 1;
      do_reset();
      for (int i = 0; i < N; i++) begin
         in_tdata[i] = W'(i + 100);
         in_tlast[i] = 1'b0;
      end
      in_tvalid  = '1;
      out_tready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if (busy !== 1'b1)
         $display("FAIL mid_busy got %b exp 1", busy);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_chk++;
      if ({busy, out_tvalid, in_tready} !== 6'h00)
         $display("FAIL async_reset got %h exp 00",
                  {busy, out_tvalid, in_tready});
      else n_pass++;
      @(negedge clk);
      in_tvalid = '0;
      reset     = 1'b0;
      for (int i = 0; i < N; i++)
         add_pkt(i, 1 + $urandom_range(4));
      build_model();
      run(2, 1, lc);
   endtask

   task automatic test_random();
      int lc;
      for (int r = 0; r < 6; r++) begin
         pm = bit'(r % 2);
         do_reset();
         for (int i = 0; i < N; i++)
            repeat ($urandom_range(3))
               add_pkt(i, 1 + $urandom_range(4));
         add_pkt($urandom_range(N - 1), 3);
         build_model();
         run(2, pm, lc);
      end
   endtask

   initial begin
      pm = 1;
      test_reset();
      test_all_four();
      test_single_requester();
      test_stall();
      test_beat_mode();
      test_reset_mid_packet();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axis_compare_arbiter.md
# axis_compare_arbiter

Packet-granular round-robin arbiter that shares one downstream AXI-Stream consumer (typically a single reference comparator) among NUM_IN DUT output streams. Each grant is locked from the first beat of a packet until its tlast beat completes, so packets never interleave on the output. It sits in the test infrastructure between several DUT stream outputs and the comparison datapath.

## Interface
- NUM_IN, 4, number of requesting streams (2..16)
- DATA_WIDTH, 32, tdata width of every stream
- PACKET_MODE, 1, 1 = lock grant until tlast; 0 = re-arbitrate after every beat (tlast ignored for locking)
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- in[NUM_IN]  AXI4S.Slave  DATA_WIDTH  requesting streams (tdata, tvalid, tready, tlast)
- out  AXI4S.Master  DATA_WIDTH  shared output stream
- grant_idx  output  IDX_W = max(1, $clog2(NUM_IN))  index of the currently granted input; valid while busy
- busy  output  1  high while a grant is held (state LOCKED)

## Operation
- States: IDLE, LOCKED.
- IDLE: if any in[i].tvalid, select the first valid i scanning from (last_grant+1) mod NUM_IN upward with wrap; register grant_idx = i, go LOCKED. No requests: stay IDLE.
- LOCKED: out carries in[grant_idx] (tdata, tvalid, tlast); in[grant_idx].tready = out.tready; all other in[j].tready = 0.
- Beat accepted (tvalid & tready) with tlast=1 (or any accepted beat when PACKET_MODE=0): last_grant <= grant_idx, go IDLE.
- In IDLE: out.tvalid = 0, all in[].tready = 0.
- Requester dropping tvalid mid-packet: grant held; out.tvalid follows it low; no re-arbitration until tlast accepted.
- Single active requester: re-granted every packet (round-robin skips idle inputs).
- Reset value of last_grant is NUM_IN-1, so input 0 wins first when all request.
- Reset asserted mid-packet: state -> IDLE immediately; partial packet is abandoned; no recovery of the tail is attempted.

## Timing
- Reset values: busy=0, grant_idx=0, out.tvalid=0, all in[].tready=0, last_grant=NUM_IN-1.
- Arbitration latency: 1 cycle from tvalid seen in IDLE to first possible transfer (grant registered).
- Packet-to-packet gap: exactly 1 idle cycle on out after each tlast transfer (IDLE cycle).
- Datapath in LOCKED: combinational, 0-cycle latency, unless AXIS_ARB_REG_OUT_EN.
- Throughput within a packet: 1 beat/cycle when out.tready held high.
- AXI-Stream rules: out.tdata/tlast stable while out.tvalid & !out.tready (guaranteed by upstream compliance plus held grant).

## Configuration
- AXIS_ARB_REG_OUT_EN defined: output passes through a 2-entry skid buffer; out.tvalid/tdata/tlast are registered, out.tready is not combinationally connected to any in[].tready; added latency 1 cycle; full throughput retained. The FSM ends the packet on tlast accepted into the skid buffer, not on out.
- Undefined: combinational pass-through as described above.

## Structure
- Shared package axis_arb_pkg: typedef enum arb_state_t {IDLE, LOCKED}; function next_rr(valid_vec, last) returning the round-robin winner index.
- Sub-module axis_skid_buffer (DATA_WIDTH param, AXI4S slave in, AXI4S master out, clk, reset), instantiated only under AXIS_ARB_REG_OUT_EN.
- IDX_W as localparam in the module.

## Test plan
- Reset then in[0..3] each present one 4-beat packet simultaneously, out.tready=1 -> packets appear on out in order 0,1,2,3, each 4 contiguous beats, one idle cycle between, busy/grant_idx track.
- in[2] alone sends three 2-beat packets back to back -> all granted to 2, grant_idx=2, 1-cycle gap each.
- in[1] packet in flight with out.tready toggling 1010 and in[3] valid throughout -> no beat from in[3] until in[1] tlast accepted; in[3].tready stays 0; out.tdata stable while stalled.
- PACKET_MODE=0, in[0] and in[1] continuously valid -> output alternates 0,1,0,1 beat by beat with idle cycle between.
- Assert reset on beat 2 of a 5-beat packet -> out.tvalid=0, busy=0, all tready=0 same cycle (async); after release, input 0 wins if all request.
- With AXIS_ARB_REG_OUT_EN, repeat first scenario -> identical out sequence delayed by 1 cycle; out.tready held low 3 cycles loses no beats.
